// File: rtl/lpf_scheduler.sv
// Four-channel first-order low-pass filter sharing one subtract/shift/add datapath.
// Define LPF_BYPASS_EN to add a per-channel bypass input.
module lpf_scheduler #(
   parameter int unsigned CLKSPEED   = 27000000,
   parameter int unsigned FILTERFREQ = 400
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [59:0] in_sound,
   output logic [59:0] out_sound,
   input  logic        cfg_we,
   input  logic [1:0]  cfg_ch,
   input  logic [2:0]  cfg_shift,
`ifdef LPF_BYPASS_EN
   input  logic [3:0]  bypass,
`endif
   output logic        busy,
   output logic        sweep_done,
   output logic        overrun
);

   localparam int unsigned SAMPLE_W  = 15;
   localparam int unsigned NUM_CH    = 4;
   localparam int unsigned CH_W      = 2;
   localparam int unsigned SHIFT_W   = 3;
   localparam int unsigned DIFF_W    = 18;
   localparam int unsigned PRESCALER = CLKSPEED / (FILTERFREQ * 32);
   localparam int unsigned CNT_W     = (PRESCALER < 2) ? 1 : $clog2(PRESCALER + 1);
   localparam int unsigned EXT_W     = DIFF_W - SAMPLE_W;

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_CALC,
      S_WRITE
   } state_t;

   state_t                     r_state;
   state_t                     w_state_nxt;
   logic [CH_W-1:0]            r_ch;
   logic [CH_W-1:0]            w_ch_nxt;
   logic [CNT_W-1:0]           r_cnt;
   logic                       w_tick;
   logic                       w_busy_nxt;
   logic                       w_done_nxt;
   logic                       w_ovr_nxt;
   logic                       r_busy;
   logic                       r_done;
   logic                       r_ovr;

   logic [SHIFT_W-1:0]         r_shift [NUM_CH];
   logic [SAMPLE_W-1:0]        r_out   [NUM_CH];
   logic [SAMPLE_W-1:0]        w_in    [NUM_CH];
   logic [SAMPLE_W-1:0]        r_out_lat;
   logic signed [DIFF_W-1:0]   w_diff;
   logic signed [DIFF_W-1:0]   r_diff;
   logic [SAMPLE_W-1:0]        r_step;
   logic [SAMPLE_W-1:0]        w_sum;
   logic [SAMPLE_W-1:0]        w_wdata;

   // Unpack the input bus and pack the registered outputs.
   for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
      assign w_in[g] = in_sound[g*SAMPLE_W +: SAMPLE_W];
      assign out_sound[g*SAMPLE_W +: SAMPLE_W] = r_out[g];
   end

   assign busy       = r_busy;
   assign sweep_done = r_done;
   assign overrun    = r_ovr;

   // Sweep-rate prescaler: tick in the cycle the counter reads zero.
   assign w_tick = (r_cnt == '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= CNT_W'(PRESCALER);
      end else if (w_tick) begin
         r_cnt <= CNT_W'(PRESCALER);
      end else begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   // Per-channel shift configuration.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            r_shift[i] <= SHIFT_W'(3);
         end
      end else if (cfg_we) begin
         r_shift[cfg_ch] <= cfg_shift;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_ch    <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_ovr   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ch    <= w_ch_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         r_ovr   <= w_ovr_nxt;
      end
   end

   // Next-state and flag logic; a tick outside IDLE is dropped and flagged.
   always_comb begin
      w_state_nxt = r_state;
      w_ch_nxt    = r_ch;
      w_done_nxt  = 1'b0;
      w_ovr_nxt   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_tick) begin
               w_state_nxt = S_READ;
               w_ch_nxt    = '0;
            end
         end
         S_READ:  w_state_nxt = S_CALC;
         S_CALC:  w_state_nxt = S_WRITE;
         S_WRITE: begin
            if (r_ch == CH_W'(NUM_CH - 1)) begin
               w_state_nxt = S_IDLE;
               w_done_nxt  = 1'b1;
            end else begin
               w_state_nxt = S_READ;
               w_ch_nxt    = r_ch + CH_W'(1);
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (w_tick && (r_state != S_IDLE)) begin
         w_ovr_nxt = 1'b1;
      end
      w_busy_nxt = (w_state_nxt != S_IDLE);
   end

   // Zero-extended operands give an exact signed difference in 18 bits.
   assign w_diff = $signed({{EXT_W{1'b0}}, w_in[r_ch]})
                 - $signed({{EXT_W{1'b0}}, r_out[r_ch]});
   assign w_sum  = r_out_lat + r_step;

`ifdef LPF_BYPASS_EN
   logic [SAMPLE_W-1:0] r_in_lat;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_in_lat <= '0;
      end else if (r_state == S_READ) begin
         r_in_lat <= w_in[r_ch];
      end
   end

   assign w_wdata = bypass[r_ch] ? r_in_lat : w_sum;
`else
   assign w_wdata = w_sum;
`endif

   // Shared datapath; the step stays between in and out so 15-bit wrap is exact.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out_lat <= '0;
         r_diff    <= '0;
         r_step    <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            r_out[i] <= '0;
         end
      end else begin
         case (r_state)
            S_READ: begin
               r_out_lat <= r_out[r_ch];
               r_diff    <= w_diff;
            end
            S_CALC: begin
               r_step <= (r_shift[r_ch] == '0) ? '0
                                               : SAMPLE_W'(r_diff >>> r_shift[r_ch]);
            end
            S_WRITE: begin
               r_out[r_ch] <= w_wdata;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: doc/lpf_scheduler.md
LPF_SCHEDULER -- requirements
Module: lpf_scheduler

Interface
REQ-001 SHALL have parameter CLKSPEED, default 27000000, system clock frequency in Hz.
REQ-002 SHALL have parameter FILTERFREQ, default 400, filter update-rate base in Hz; PRESCALER = CLKSPEED/(FILTERFREQ*32), integer division.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on posedge clk.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_sound  input  60  four 15-bit unsigned channel samples; channel n occupies bits [15n+14:15n].
REQ-006 SHALL have port out_sound  output  60  four registered 15-bit filtered outputs, same packing as in_sound.
REQ-007 SHALL have port cfg_we  input  1  per-channel shift write strobe.
REQ-008 SHALL have port cfg_ch  input  2  channel index for the cfg_we write.
REQ-009 SHALL have port cfg_shift  input  3  shift value to write.
REQ-010 SHALL have port busy  output  1  high while a sweep is in progress.
REQ-011 SHALL have port sweep_done  output  1  one-cycle pulse at the end of a sweep.
REQ-012 SHALL have port overrun  output  1  one-cycle pulse when a tick is dropped.

Function
REQ-013 SHALL share one subtract/shift/add datapath across all four channels, sequenced by an FSM with states IDLE, READ, CALC and WRITE.
REQ-014 SHALL run a down-counter reloaded to PRESCALER.
- The tick fires in the cycle the counter is 0; the counter reloads at that edge.
- Tick period is PRESCALER+1 cycles.
REQ-015 SHALL, on a tick in IDLE, clear the channel index to 0 and enter READ on the next edge.
REQ-016 SHALL, on a tick in any non-IDLE state, drop the tick, pulse overrun for one cycle and leave the sweep undisturbed.
REQ-017 SHALL, in READ, latch in_sound[ch] and out_sound[ch] and form diff = in - out as an 18-bit signed value from zero-extended operands.
REQ-018 SHALL, in CALC, form step = diff arithmetically right-shifted by shift[ch], with sign preserved (floor).
REQ-019 SHALL, in WRITE, load out_sound[ch] with out + step truncated to 15 bits; the output is unchanged when in == out or shift[ch] == 0.
REQ-020 SHALL, after WRITE, advance to READ for ch+1 when ch < 3, else return to IDLE.
- A sweep is exactly 12 cycles: READ at T+1, last WRITE at T+12, where T is the tick cycle.
REQ-021 SHALL assert sweep_done for one cycle at T+13, the first cycle the channel-3 update is visible.
REQ-022 SHALL assert busy in every non-IDLE state.
REQ-023 SHALL treat shift[ch] = 0 as channel hold: out_sound[ch] is frozen and the channel still takes its 3-cycle slot.
REQ-024 SHALL treat shift values 1..7 as valid; out_sound never crosses in_sound and never overflows 15 bits.
REQ-025 SHALL, on cfg_we, update shift[cfg_ch] at that edge.
- CALC uses the registered shift present in its cycle.
- A write landing in the same cycle as that channel's CALC takes effect from the next sweep.

Reset
REQ-026 SHALL, while reset is high and independent of clk, force:
- out_sound to 0, FSM to IDLE, channel index to 0;
- prescaler to PRESCALER, all shift[ch] to 3;
- busy, sweep_done and overrun to 0.
REQ-027 SHALL abandon a sweep interrupted by reset with no partial write; the first tick after release starts a full sweep from channel 0.

Configuration
REQ-028 SHALL, with macro LPF_BYPASS_EN defined, add port bypass, input, 4 bits.
- In a bypassed channel's WRITE, out_sound[ch] loads in_sound[ch] directly; slot timing is unchanged.
REQ-029 SHALL, without LPF_BYPASS_EN, have no bypass port and filter every channel.

Verification (CLKSPEED=12800, FILTERFREQ=20, so PRESCALER=20, unless noted)
REQ-030 SHALL cover step response: ch0 in=0x4000, out=0, shift 3 -> 0x0800 after sweep 1, 0x0F00 after sweep 2; sweep_done pulses 13 cycles after each tick.
REQ-031 SHALL cover negative step: ch1 out=0x0F00, in=0, shift 3 -> 0x0D20 after one sweep; an out of 5 toward in=0 reaches 0 after exactly 5 sweeps.
REQ-032 SHALL cover hold and config: cfg_we with ch2 shift 0 -> out_sound[2] constant over 10 sweeps; rewrite shift 1 with in=0x0100 from 0 -> 0x0080.
REQ-033 SHALL cover overrun: override PRESCALER to 5 (FILTERFREQ=80, CLKSPEED=12800) -> a tick dropped while busy, overrun pulses once per dropped tick, all four channels still updated each sweep.
REQ-034 SHALL cover async reset mid-sweep: reset asserted during ch2 CALC -> all outputs 0 immediately, ch3 not written, next tick sweeps from ch0.
REQ-035 SHALL cover bypass, with LPF_BYPASS_EN: bypass=4'b1000, in3=0x1234 -> out_sound[3]=0x1234 after one sweep while ch0-2 filter normally.
